harmonic_sum_sequencer: RTL and testbench

- Initiator side of the per-harmonic attenuation handshake (restart / start / mult / ready) on the additive voice path.
- On each sample tick it:
  - restarts the scale multiplier to its initial level;
  - walks harmonics 0..N-1, fetching each harmonic sample and multiplying it by the current attenuation multiple;
  - steps the multiplier between harmonics and accumulates the products.
- Emits one saturated, rescaled output sample per tick to the DAC/output stage.

---
 rtl/harmonic_sum_sequencer.sv | 150 +++++++++++++++
 tb/tb_harmonic_sum_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/harmonic_sum_sequencer.sv
// Harmonic sum sequencer: per sample tick, walks harmonics 0..N-1, scales each by the attenuation multiplier, accumulates, emits a saturated sample.
// Latency: 5N-1 cycles tick-to-valid (N>=1), 2 cycles for N=0, 5k+2 on early termination after k multiplier steps.
// Backpressure: waits on i_Mult_Ready after each step (no timeout); ticks arriving while busy are dropped and flagged on o_Overrun.
//
// Ports:
//   i_Clock, i_Reset              clock, async active-high reset
//   i_Sample_Tick                 start a new output sample (1-cycle pulse)
//   i_Harmonic_Count              harmonics to sum (clamped to 2^HARM_BIT)
//   o_Restart / o_Start           multiplier reload / step pulses
//   i_Mult, i_Mult_Ready          current attenuation multiple and its valid flag
//   o_Harmonic, i_Harmonic_Sample lookup address and its registered data
//   o_Sum, o_Sum_Valid            output sample and update pulse
//   o_Busy, o_Overrun             sequence in progress, dropped-tick pulse
module harmonic_sum_sequencer #(
  parameter int DIV_BIT    = 11,
  parameter int SAMPLE_BIT = 16,
  parameter int HARM_BIT   = 6
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Sample_Tick,
  input  logic [HARM_BIT:0]     i_Harmonic_Count,
  output logic                  o_Restart,
  output logic                  o_Start,
  input  logic [DIV_BIT-1:0]    i_Mult,
  input  logic                  i_Mult_Ready,
  output logic [HARM_BIT-1:0]   o_Harmonic,
  input  logic [SAMPLE_BIT-1:0] i_Harmonic_Sample,
  output logic [SAMPLE_BIT-1:0] o_Sum,
  output logic                  o_Sum_Valid,
  output logic                  o_Busy,
  output logic                  o_Overrun
);

  localparam int CNT_W  = HARM_BIT + 1;
  localparam int PROD_W = SAMPLE_BIT + DIV_BIT + 1;
  localparam int ACC_W  = SAMPLE_BIT + DIV_BIT + HARM_BIT + 1;

  localparam logic [CNT_W-1:0]        MAX_HARM = CNT_W'(1 << HARM_BIT);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (SAMPLE_BIT - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE, S_RESTART, S_FETCH, S_ACCUM, S_STEP, S_WAIT, S_DONE
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]        count_q;
  logic [HARM_BIT-1:0]     harm_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [SAMPLE_BIT-1:0]   sum_q;
  logic                    wait_first_q;

  logic [CNT_W-1:0]        count_clamped;
  logic                    last_harm;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] shifted;
  logic [SAMPLE_BIT-1:0]   sat_sum;

  assign count_clamped = (i_Harmonic_Count > MAX_HARM) ? MAX_HARM : i_Harmonic_Count;
  assign last_harm     = ({1'b0, harm_q} == (count_q - CNT_W'(1)));

  // Multiplier value is unsigned, so a zero sign bit is prepended before the signed multiply.
  assign prod     = $signed(i_Harmonic_Sample) * $signed({1'b0, i_Mult});
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign shifted  = acc_q >>> DIV_BIT;

  always_comb begin
    sat_sum = shifted[SAMPLE_BIT-1:0];
    if (shifted > SAT_MAX)
      sat_sum = SAT_MAX[SAMPLE_BIT-1:0];
    else if (shifted < SAT_MIN)
      sat_sum = SAT_MIN[SAMPLE_BIT-1:0];
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state  = state;
    o_Restart   = 1'b0;
    o_Start     = 1'b0;
    o_Sum_Valid = 1'b0;
    o_Busy      = (state != S_IDLE);
    o_Overrun   = i_Sample_Tick && (state != S_IDLE);
    // Present the fresh sum during the valid cycle; hold the register otherwise.
    o_Sum       = sum_q;
    case (state)
      S_IDLE:    if (i_Sample_Tick) next_state = S_RESTART;
      S_RESTART: begin
        o_Restart  = 1'b1;
        next_state = (count_q == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH:   next_state = S_ACCUM;
      S_ACCUM:   next_state = last_harm ? S_DONE : S_STEP;
      S_STEP: begin
        o_Start    = 1'b1;
        next_state = S_WAIT;
      end
      S_WAIT: begin
        // The responder only drops ready one cycle after start, so the first WAIT cycle is blind.
        if (!wait_first_q && i_Mult_Ready)
          next_state = (i_Mult == '0) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        o_Sum_Valid = 1'b1;
        o_Sum       = sat_sum;
        next_state  = S_IDLE;
      end
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      count_q      <= '0;
      harm_q       <= '0;
      acc_q        <= '0;
      sum_q        <= '0;
      wait_first_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          harm_q <= '0;
          if (i_Sample_Tick) begin
            count_q <= count_clamped;
            acc_q   <= '0;
          end
        end
        S_ACCUM: acc_q <= acc_q + prod_ext;
        S_STEP: begin
          harm_q       <= harm_q + 1'b1;
          wait_first_q <= 1'b1;
        end
        S_WAIT:  wait_first_q <= 1'b0;
        S_DONE:  sum_q <= sat_sum;
        default: ;
      endcase
    end
  end

  assign o_Harmonic = harm_q;

endmodule

// File: tb/tb_harmonic_sum_sequencer.sv
// Bench for harmonic_sum_sequencer: multiplier responder and lookup table models, arithmetic reference of the harmonic sum.
// Latency: n/a (bench).
// Backpressure: responder holds ready low for 1+delay cycles after each start pulse.
module tb_harmonic_sum_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [6:0]  hcount;
  logic        restart_p, start_p;
  logic [10:0] mult;
  logic        mult_rdy;
  logic [5:0]  harm;
  logic [15:0] hsample;
  logic [15:0] sum;
  logic        sum_vld, busy, overrun;

  harmonic_sum_sequencer dut (
    .i_Clock(clk), .i_Reset(rst), .i_Sample_Tick(tick), .i_Harmonic_Count(hcount),
    .o_Restart(restart_p), .o_Start(start_p), .i_Mult(mult), .i_Mult_Ready(mult_rdy),
    .o_Harmonic(harm), .i_Harmonic_Sample(hsample), .o_Sum(sum), .o_Sum_Valid(sum_vld),
    .o_Busy(busy), .o_Overrun(overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int samp_tab[64];
  int delay_tab[64];
  int init_mult;
  int scale;
  int step_idx;
  int busy_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered lookup table plus multiplier responder.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_rdy <= 1'b1;
      mult     <= '0;
      hsample  <= '0;
      step_idx <= 0;
      busy_cnt <= 0;
    end else begin
      hsample <= 16'(samp_tab[harm]);
      if (restart_p) begin
        mult     <= 11'(init_mult);
        step_idx <= 0;
      end
      if (start_p) begin
        mult_rdy <= 1'b0;
        busy_cnt <= delay_tab[step_idx];
        step_idx <= step_idx + 1;
      end else if (!mult_rdy) begin
        if (busy_cnt == 0) begin
          mult_rdy <= 1'b1;
          mult     <= (int'(mult) > scale) ? 11'(int'(mult) - scale) : 11'd0;
        end else begin
          busy_cnt <= busy_cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: weighted sum with a multiplier that starts at init_mult and drops by scale per step.
  task automatic model(input int n_raw, output longint exp_sum, output int exp_lat, output int exp_starts);
    int n;
    int m;
    longint acc;
    n = (n_raw > 64) ? 64 : n_raw;
    m = init_mult;
    acc = 0;
    exp_starts = 0;
    if (n == 0) begin
      exp_lat = 2;
    end else begin
      exp_lat = 1;
      for (int i = 0; i < n; i++) begin
        exp_lat += 2;
        acc += longint'(samp_tab[i]) * longint'(m);
        if (i == n - 1) begin
          exp_lat += 1;
          break;
        end
        exp_starts++;
        exp_lat += 3 + delay_tab[i];
        m = (m > scale) ? m - scale : 0;
        if (m == 0) begin
          exp_lat += 1;
          break;
        end
      end
    end
    acc = acc >>> 11;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    exp_sum = acc;
  endtask

  // One tick-to-valid sequence; ov_at>0 injects an extra tick that many cycles after the accepted one.
  task automatic run_case(input string tag, input int n, input int ov_at);
    longint exp_sum;
    int exp_lat, exp_starts;
    int t0, lat, n_restart, n_start, n_valid, n_ovr, busy_at_vld;
    longint got_sum;
    model(n, exp_sum, exp_lat, exp_starts);
    n_restart = 0; n_start = 0; n_valid = 0; n_ovr = 0;
    lat = -1; got_sum = 0; busy_at_vld = 0;
    @(posedge clk); #1;
    hcount = 7'(n);
    tick = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (restart_p) n_restart++;
      if (start_p) n_start++;
      if (overrun) n_ovr++;
      if (sum_vld) begin
        n_valid++;
        lat = cyc - t0;
        got_sum = longint'($signed(sum));
        busy_at_vld = int'(busy);
      end
      if (cyc - t0 > exp_lat + 3) break;
      @(posedge clk); #1;
      tick = (ov_at > 0) && (cyc - t0 == ov_at);
      hcount = 7'($urandom_range(0, 127));
    end
    tick = 1'b0;
    check({tag, " sum"}, got_sum, exp_sum);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " restarts"}, n_restart, 1);
    check({tag, " starts"}, n_start, exp_starts);
    check({tag, " valids"}, n_valid, 1);
    check({tag, " overruns"}, n_ovr, (ov_at > 0) ? 1 : 0);
    check({tag, " busy@valid"}, busy_at_vld, 1);
  endtask

  task automatic fill(input int s, input int d);
    for (int i = 0; i < 64; i++) begin
      samp_tab[i]  = s;
      delay_tab[i] = d;
    end
  endtask

  initial begin
    int n_valid;
    rst = 1'b1; tick = 1'b0; hcount = '0;
    init_mult = 0; scale = 0;
    fill(0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset sum", sum, 0);
    check("reset busy", busy, 0);
    check("reset harm", harm, 0);
    check("reset restart", restart_p, 0);
    check("reset start", start_p, 0);
    check("reset valid", sum_vld, 0);
    @(negedge clk); rst = 1'b0;

    init_mult = 1024; scale = 256; fill(1000, 0);
    run_case("n1", 1, 0);
    fill(2000, 0);
    run_case("n3", 3, 0);
    init_mult = 512; fill(2048, 0);
    run_case("early", 5, 0);
    init_mult = 2047; scale = 0; fill(32767, 0);
    run_case("satpos", 64, 0);
    fill(-32768, 0);
    run_case("satneg", 64, 0);
    run_case("clamp100", 100, 0);
    run_case("n0", 0, 0);
    init_mult = 1024; scale = 100; fill(-1234, 1);
    run_case("ovr_mid", 4, 5);
    run_case("ovr_done", 2, 9);

    // Reset while waiting on the multiplier for harmonic 3.
    init_mult = 2047; scale = 10; fill(3000, 0);
    @(posedge clk); #1;
    hcount = 7'd8; tick = 1'b1;
    @(posedge clk); #1; tick = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (start_p && harm == 6'd2) break;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid sum", sum, 0);
    check("rst_mid busy", busy, 0);
    check("rst_mid harm", harm, 0);
    check("rst_mid start", start_p, 0);
    check("rst_mid valid", sum_vld, 0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    n_valid = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sum_vld) n_valid++;
    end
    check("rst_mid no valid", n_valid, 0);
    run_case("after_rst", 6, 0);

    for (int r = 0; r < 25; r++) begin
      int n, ov, t;
      longint es; int el, est;
      n = $urandom_range(0, 80);
      init_mult = $urandom_range(0, 2047);
      scale = $urandom_range(0, 400);
      for (int i = 0; i < 64; i++) begin
        samp_tab[i]  = int'($urandom_range(0, 65535)) - 32768;
        delay_tab[i] = $urandom_range(0, 3);
      end
      model(n, es, el, est);
      t = $urandom_range(0, 2);
      ov = (t == 0) ? int'($urandom_range(1, el)) : 0;
      run_case($sformatf("rand%0d", r), n, ov);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
